// File: rtl/alu_issue_stage_if.sv
// Handshake and operand bundle between register read, the issue stage and the ALU.
// master = environment side (upstream and execute), slave = issue stage.
interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_val;
  logic [XLEN-1:0] in_rs2_val;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [3:0]      out_aluctrl;
  logic [XLEN-1:0] out_store_data;
  logic [2:0]      out_funct3;
  logic            out_is_branch;
  logic            out_is_jump;
  logic            out_is_load;
  logic            out_is_store;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_aluctrl, out_store_data,
           out_funct3, out_is_branch, out_is_jump, out_is_load, out_is_store,
           out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_aluctrl, out_store_data,
           out_funct3, out_is_branch, out_is_jump, out_is_load, out_is_store,
           out_illegal, out_pc
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes one instruction per cycle into ALU control and operands
// behind a single output register. Optional flush port enabled by ALU_ISSUE_FLUSH_EN.
module alu_issue_stage (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_stage_if.slave io
`ifdef ALU_ISSUE_FLUSH_EN
  ,
  input  logic             flush
`endif
);
  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1111;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  // Instruction fields
  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_s_s;
  logic [XLEN-1:0] imm_u_s;
  logic [XLEN-1:0] shamt_s;
  logic            rs_idx_unused;

  assign opcode_s      = io.in_instr[6:0];
  assign funct3_s      = io.in_instr[14:12];
  assign funct7_s      = io.in_instr[31:25];
  assign imm_i_s       = {{20{io.in_instr[31]}}, io.in_instr[31:20]};
  assign imm_s_s       = {{20{io.in_instr[31]}}, io.in_instr[31:25], io.in_instr[11:7]};
  assign imm_u_s       = {io.in_instr[31:12], 12'h000};
  assign shamt_s       = {27'd0, io.in_instr[24:20]};
  assign rs_idx_unused = ^io.in_instr[19:15];

  // Raw decode before illegal-instruction squashing
  logic [XLEN-1:0] raw_op1_s;
  logic [XLEN-1:0] raw_op2_s;
  logic [XLEN-1:0] raw_sd_s;
  logic [3:0]      raw_ctrl_s;
  logic            raw_br_s;
  logic            raw_jp_s;
  logic            raw_ld_s;
  logic            raw_st_s;
  logic            illegal_s;

  // Next-state values of the output register
  logic [XLEN-1:0] op1_d, op2_d, sd_d, pc_d;
  logic [3:0]      ctrl_d;
  logic [2:0]      funct3_d;
  logic            br_d, jp_d, ld_d, st_d, ill_d;
  logic            valid_d;

  logic [XLEN-1:0] op1_q, op2_q, sd_q, pc_q;
  logic [3:0]      ctrl_q;
  logic [2:0]      funct3_q;
  logic            br_q, jp_q, ld_q, st_q, ill_q;
  logic            valid_q;

  logic            ready_s;
  logic            capture_s;

  // Opcode/funct decode into operand selection, ALU code and class flags
  always_comb begin
    raw_op1_s  = '0;
    raw_op2_s  = '0;
    raw_sd_s   = '0;
    raw_ctrl_s = ALU_ADD;
    raw_br_s   = 1'b0;
    raw_jp_s   = 1'b0;
    raw_ld_s   = 1'b0;
    raw_st_s   = 1'b0;
    illegal_s  = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        raw_op1_s = io.in_rs1_val;
        raw_op2_s = io.in_rs2_val;
        case ({funct7_s, funct3_s})
          {F7_BASE, 3'b000}: raw_ctrl_s = ALU_ADD;
          {F7_BASE, 3'b001}: raw_ctrl_s = ALU_SLL;
          {F7_BASE, 3'b010}: raw_ctrl_s = ALU_SLT;
          {F7_BASE, 3'b011}: raw_ctrl_s = ALU_SLTU;
          {F7_BASE, 3'b100}: raw_ctrl_s = ALU_XOR;
          {F7_BASE, 3'b101}: raw_ctrl_s = ALU_SRL;
          {F7_BASE, 3'b110}: raw_ctrl_s = ALU_OR;
          {F7_BASE, 3'b111}: raw_ctrl_s = ALU_AND;
          {F7_ALT,  3'b000}: raw_ctrl_s = ALU_SUB;
          {F7_ALT,  3'b101}: raw_ctrl_s = ALU_SRA;
          default:           illegal_s  = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        raw_op1_s = io.in_rs1_val;
        raw_op2_s = imm_i_s;
        case (funct3_s)
          3'b000: raw_ctrl_s = ALU_ADD;
          3'b010: raw_ctrl_s = ALU_SLT;
          3'b011: raw_ctrl_s = ALU_SLTU;
          3'b100: raw_ctrl_s = ALU_XOR;
          3'b110: raw_ctrl_s = ALU_OR;
          3'b111: raw_ctrl_s = ALU_AND;
          3'b001: begin
            raw_op2_s  = shamt_s;
            raw_ctrl_s = ALU_SLL;
            illegal_s  = (funct7_s != F7_BASE);
          end
          3'b101: begin
            raw_op2_s = shamt_s;
            if (funct7_s == F7_BASE) begin
              raw_ctrl_s = ALU_SRL;
            end else if (funct7_s == F7_ALT) begin
              raw_ctrl_s = ALU_SRA;
            end else begin
              illegal_s = 1'b1;
            end
          end
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_LUI: begin
        raw_op2_s = imm_u_s;
      end
      OPC_AUIPC: begin
        raw_op1_s = io.in_pc;
        raw_op2_s = imm_u_s;
      end
      OPC_LOAD: begin
        raw_op1_s = io.in_rs1_val;
        raw_op2_s = imm_i_s;
        raw_ld_s  = 1'b1;
      end
      OPC_STORE: begin
        raw_op1_s = io.in_rs1_val;
        raw_op2_s = imm_s_s;
        raw_sd_s  = io.in_rs2_val;
        raw_st_s  = 1'b1;
      end
      OPC_BRANCH: begin
        raw_op1_s = io.in_rs1_val;
        raw_op2_s = io.in_rs2_val;
        raw_br_s  = 1'b1;
        case (funct3_s)
          3'b000, 3'b001: raw_ctrl_s = ALU_SUB;
          3'b100, 3'b101: raw_ctrl_s = ALU_SLT;
          3'b110, 3'b111: raw_ctrl_s = ALU_SLTU;
          default:        illegal_s  = 1'b1;
        endcase
      end
      OPC_JAL: begin
        raw_op1_s = io.in_pc;
        raw_op2_s = 32'd4;
        raw_jp_s  = 1'b1;
      end
      OPC_JALR: begin
        raw_op1_s = io.in_pc;
        raw_op2_s = 32'd4;
        raw_jp_s  = 1'b1;
        illegal_s = (funct3_s != 3'b000);
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // Illegal encodings issue as a plain beat with zeroed operands and only the illegal flag
  always_comb begin
    funct3_d = funct3_s;
    pc_d     = io.in_pc;
    ill_d    = illegal_s;
    if (illegal_s) begin
      op1_d  = '0;
      op2_d  = '0;
      sd_d   = '0;
      ctrl_d = ALU_ADD;
      br_d   = 1'b0;
      jp_d   = 1'b0;
      ld_d   = 1'b0;
      st_d   = 1'b0;
    end else begin
      op1_d  = raw_op1_s;
      op2_d  = raw_op2_s;
      sd_d   = raw_sd_s;
      ctrl_d = raw_ctrl_s;
      br_d   = raw_br_s;
      jp_d   = raw_jp_s;
      ld_d   = raw_ld_s;
      st_d   = raw_st_s;
    end
  end

`ifdef ALU_ISSUE_FLUSH_EN
  assign ready_s = !flush && (!valid_q || io.out_ready);
  assign valid_d = flush ? 1'b0 : (capture_s ? 1'b1 : (io.out_ready ? 1'b0 : valid_q));
`else
  assign ready_s = !valid_q || io.out_ready;
  assign valid_d = capture_s ? 1'b1 : (io.out_ready ? 1'b0 : valid_q);
`endif
  assign capture_s = io.in_valid && ready_s;

  // Output-valid register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Output data register; holds while no new beat is captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q    <= '0;
      op2_q    <= '0;
      sd_q     <= '0;
      pc_q     <= '0;
      ctrl_q   <= 4'b0000;
      funct3_q <= 3'b000;
      br_q     <= 1'b0;
      jp_q     <= 1'b0;
      ld_q     <= 1'b0;
      st_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else if (capture_s) begin
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      sd_q     <= sd_d;
      pc_q     <= pc_d;
      ctrl_q   <= ctrl_d;
      funct3_q <= funct3_d;
      br_q     <= br_d;
      jp_q     <= jp_d;
      ld_q     <= ld_d;
      st_q     <= st_d;
      ill_q    <= ill_d;
    end
  end

  assign io.in_ready       = ready_s;
  assign io.out_valid      = valid_q;
  assign io.out_op1        = op1_q;
  assign io.out_op2        = op2_q;
  assign io.out_store_data = sd_q;
  assign io.out_pc         = pc_q;
  assign io.out_aluctrl    = ctrl_q;
  assign io.out_funct3     = funct3_q;
  assign io.out_is_branch  = br_q;
  assign io.out_is_jump    = jp_q;
  assign io.out_is_load    = ld_q;
  assign io.out_is_store   = st_q;
  assign io.out_illegal    = ill_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage against an instruction-level reference decoder
// with a scoreboard of issued beats.
module tb_alu_issue_stage;
  typedef struct {
    logic [31:0] op1, op2, sd, pc;
    logic [3:0]  ctrl;
    logic [2:0]  f3;
    logic        br, jp, ld, st, il;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   dut_fires = 0;
  int   model_fires = 0;
  beat_t exp_q[$];

  alu_issue_stage_if io ();

  alu_issue_stage dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
`ifdef ALU_ISSUE_FLUSH_EN
    ,
    .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decoder written from the instruction-set rules.
  function automatic beat_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] a, input logic [31:0] b);
    beat_t r;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [31:0] i_imm, s_imm, u_imm, sh;
    logic ok;
    opc = ins[6:0];
    f7 = ins[31:25];
    f3 = ins[14:12];
    i_imm = {{20{ins[31]}}, ins[31:20]};
    s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    u_imm = {ins[31:12], 12'h000};
    sh = {27'd0, ins[24:20]};
    ok = 1'b1;
    r.op1 = 32'd0; r.op2 = 32'd0; r.sd = 32'd0; r.pc = pc; r.ctrl = 4'd0; r.f3 = f3;
    r.br = 1'b0; r.jp = 1'b0; r.ld = 1'b0; r.st = 1'b0; r.il = 1'b0;
    case (opc)
      7'h33: begin
        r.op1 = a; r.op2 = b;
        if (f7 == 7'h00) r.ctrl = {1'b0, f3};
        else if (f7 == 7'h20 && f3 == 3'd0) r.ctrl = 4'b1000;
        else if (f7 == 7'h20 && f3 == 3'd5) r.ctrl = 4'b1111;
        else ok = 1'b0;
      end
      7'h13: begin
        r.op1 = a;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          r.op2 = sh;
          if (f7 == 7'h00) r.ctrl = {1'b0, f3};
          else if (f3 == 3'd5 && f7 == 7'h20) r.ctrl = 4'b1111;
          else ok = 1'b0;
        end else begin
          r.op2 = i_imm; r.ctrl = {1'b0, f3};
        end
      end
      7'h37: r.op2 = u_imm;
      7'h17: begin r.op1 = pc; r.op2 = u_imm; end
      7'h03: begin r.op1 = a; r.op2 = i_imm; r.ld = 1'b1; end
      7'h23: begin r.op1 = a; r.op2 = s_imm; r.st = 1'b1; r.sd = b; end
      7'h63: begin
        r.op1 = a; r.op2 = b; r.br = 1'b1;
        if (f3 <= 3'd1) r.ctrl = 4'b1000;
        else if (f3 == 3'd4 || f3 == 3'd5) r.ctrl = 4'b0010;
        else if (f3 >= 3'd6) r.ctrl = 4'b0011;
        else ok = 1'b0;
      end
      7'h6F: begin r.op1 = pc; r.op2 = 32'd4; r.jp = 1'b1; end
      7'h67: begin r.op1 = pc; r.op2 = 32'd4; r.jp = 1'b1; ok = (f3 == 3'd0); end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      r.op1 = 32'd0; r.op2 = 32'd0; r.sd = 32'd0; r.ctrl = 4'd0;
      r.br = 1'b0; r.jp = 1'b0; r.ld = 1'b0; r.st = 1'b0; r.il = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] tab [10];
    logic [31:0] ins;
    int pick;
    tab = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h0B};
    ins = $urandom();
    pick = $urandom_range(0, 10);
    if (pick < 10) ins[6:0] = tab[pick];
    pick = $urandom_range(0, 9);
    if (pick < 5) ins[31:25] = 7'h00;
    else if (pick < 8) ins[31:25] = 7'h20;
    return ins;
  endfunction

  task automatic check_cleared(input string tag);
    check_eq({tag, "_valid"}, {31'd0, io.out_valid}, 32'd0);
    check_eq({tag, "_ready"}, {31'd0, io.in_ready}, 32'd1);
    check_eq({tag, "_op1"}, io.out_op1, 32'd0);
    check_eq({tag, "_op2"}, io.out_op2, 32'd0);
    check_eq({tag, "_sd"}, io.out_store_data, 32'd0);
    check_eq({tag, "_pc"}, io.out_pc, 32'd0);
    check_eq({tag, "_ctrl"}, {28'd0, io.out_aluctrl}, 32'd0);
    check_eq({tag, "_f3"}, {29'd0, io.out_funct3}, 32'd0);
    check_eq({tag, "_flags"}, {27'd0, io.out_is_branch, io.out_is_jump, io.out_is_load,
                               io.out_is_store, io.out_illegal}, 32'd0);
  endtask

  // One cycle, entered and left at a falling edge: check held outputs, drive, predict.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b, input logic ordy,
                      input logic fl, output logic acc);
    logic exp_rdy, fl_eff;
    check_eq("out_valid", {31'd0, io.out_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check_eq("op1", io.out_op1, exp_q[0].op1);
      check_eq("op2", io.out_op2, exp_q[0].op2);
      check_eq("store_data", io.out_store_data, exp_q[0].sd);
      check_eq("pc", io.out_pc, exp_q[0].pc);
      check_eq("aluctrl", {28'd0, io.out_aluctrl}, {28'd0, exp_q[0].ctrl});
      check_eq("funct3", {29'd0, io.out_funct3}, {29'd0, exp_q[0].f3});
      check_eq("flags", {27'd0, io.out_is_branch, io.out_is_jump, io.out_is_load,
                         io.out_is_store, io.out_illegal},
               {27'd0, exp_q[0].br, exp_q[0].jp, exp_q[0].ld, exp_q[0].st, exp_q[0].il});
    end
`ifdef ALU_ISSUE_FLUSH_EN
    fl_eff = fl;
`else
    fl_eff = 1'b0;
`endif
    io.in_valid = v; io.in_instr = ins; io.in_pc = pc;
    io.in_rs1_val = a; io.in_rs2_val = b; io.out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !fl_eff && (exp_q.size() == 0 || ordy);
    check_eq("in_ready", {31'd0, io.in_ready}, {31'd0, exp_rdy});
    if (io.out_valid && ordy && !fl_eff) dut_fires++;
    acc = v && exp_rdy;
    if (fl_eff) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && ordy) begin
        void'(exp_q.pop_front());
        model_fires++;
      end
      if (acc) exp_q.push_back(model_decode(ins, pc, a, b));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    logic pend;
    logic [31:0] ins, pc, a, b;
    int idx;
    logic [31:0] stream [4];
    io.in_valid = 1'b0; io.in_instr = 32'd0; io.in_pc = 32'd0;
    io.in_rs1_val = 32'd0; io.in_rs2_val = 32'd0; io.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    // sub x3,x1,x2
    step(1'b1, 32'h402081B3, 32'h0000_0040, 32'd10, 32'd3, 1'b1, 1'b0, acc);
    check_eq("sub_valid", {31'd0, io.out_valid}, 32'd1);
    check_eq("sub_ctrl", {28'd0, io.out_aluctrl}, 32'h8);
    check_eq("sub_op1", io.out_op1, 32'd10);
    check_eq("sub_op2", io.out_op2, 32'd3);

    // srai x5,x6,4 and its illegal imm[11:5]=0x10 variant
    step(1'b1, 32'h40435293, 32'h44, 32'hF000_0000, 32'h1234, 1'b1, 1'b0, acc);
    check_eq("srai_ctrl", {28'd0, io.out_aluctrl}, 32'hF);
    check_eq("srai_op2", io.out_op2, 32'd4);
    check_eq("srai_op1", io.out_op1, 32'hF000_0000);
    step(1'b1, 32'h20435293, 32'h48, 32'hF000_0000, 32'h1234, 1'b1, 1'b0, acc);
    check_eq("srai_bad_ill", {31'd0, io.out_illegal}, 32'd1);
    check_eq("srai_bad_ctrl", {28'd0, io.out_aluctrl}, 32'h0);
    check_eq("srai_bad_op1", io.out_op1, 32'd0);
    check_eq("srai_bad_op2", io.out_op2, 32'd0);

    ins = {7'd0, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011};
    step(1'b1, ins, 32'h4C, 32'd1, 32'd2, 1'b1, 1'b0, acc);
    check_eq("bltu_br", {31'd0, io.out_is_branch}, 32'd1);
    check_eq("bltu_ctrl", {28'd0, io.out_aluctrl}, 32'h3);
    check_eq("bltu_f3", {29'd0, io.out_funct3}, 32'h6);

    step(1'b1, 32'h0000006F, 32'h100, $urandom(), $urandom(), 1'b1, 1'b0, acc);
    check_eq("jal_op1", io.out_op1, 32'h100);
    check_eq("jal_op2", io.out_op2, 32'd4);
    check_eq("jal_jump", {31'd0, io.out_is_jump}, 32'd1);

    // Stream of four with out_ready low on cycles 2-3; upstream holds until accepted
    stream = '{32'h00208033, 32'h0020F1B3, 32'h0040A283, 32'h0050A423};
    idx = 0;
    for (int cyc = 0; cyc < 12 && (idx < 4 || exp_q.size() != 0); cyc++) begin
      step(idx < 4, (idx < 4) ? stream[idx & 3] : 32'd0, 32'h200 + 32'(idx * 4),
           32'h1000 + 32'(idx), 32'h2000 + 32'(idx), !(cyc == 1 || cyc == 2), 1'b0, acc);
      if (acc) idx++;
    end
    check_eq("stream_accepted", 32'(idx), 32'd4);
    check_eq("stream_drained", {31'd0, io.out_valid}, 32'd0);

    // Randomized traffic; upstream keeps a beat stable until it is taken
    pend = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 9) < 7);
        ins = rand_instr(); pc = $urandom(); a = $urandom(); b = $urandom();
      end
      step(pend, ins, pc, a, b, $urandom_range(0, 9) < 6, 1'b0, acc);
      if (acc) pend = 1'b0;
    end
    for (int cyc = 0; cyc < 3; cyc++) step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
    check_eq("fire_count", 32'(dut_fires), 32'(model_fires));

    // Reset asserted between edges while a beat is stalled
    step(1'b1, 32'h00208033, 32'h300, 32'd7, 32'd9, 1'b0, 1'b0, acc);
    step(1'b1, 32'h40208033, 32'h304, 32'd7, 32'd9, 1'b0, 1'b0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("rst_stall");
    exp_q.delete();
    io.in_valid = 1'b1;
    io.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_cleared("rst_hold");
    rst_n = 1'b1;
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc);

`ifdef ALU_ISSUE_FLUSH_EN
    step(1'b1, 32'h00208033, 32'h400, 32'd5, 32'd6, 1'b0, 1'b0, acc);
    step(1'b1, 32'h0020F1B3, 32'h404, 32'd5, 32'd6, 1'b0, 1'b1, acc);
    check_eq("flush_valid", {31'd0, io.out_valid}, 32'd0);
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
    check_eq("flush_no_capture", {31'd0, io.out_valid}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered decode/issue stage that drives the ALU operand and control interface. It accepts one RV32I instruction per cycle with its PC and register-file operands over a valid/ready handshake. It decodes the instruction into the 4-bit ALU control code and the two 32-bit operands, and presents them to the execute stage through an output register. It sits between register read and the ALU, and also carries the branch, jump, store and illegal-instruction side information the execute stage needs.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction address.
- in_rs1_val, in_rs2_val  in  32  register-file read data.
- out_valid  out  1  output register holds an issued op.
- out_ready  in  1  execute stage consumes this cycle.
- out_op1, out_op2  out  32  ALU operands.
- out_aluctrl  out  4  ALU operation code.
- out_store_data  out  32  rs2 value for stores, else 0.
- out_funct3  out  3  instr[14:12], passed through for branch/load/store sizing.
- out_is_branch, out_is_jump, out_is_load, out_is_store, out_illegal  out  1  class flags.
- out_pc  out  32  captured in_pc.
- flush  in  1  only present with ALU_ISSUE_FLUSH_EN.

## Operation
- ALU codes: ADD 0000, SUB 1000, AND 0111, OR 0110, XOR 0100, SLL 0001, SRL 0101, SRA 1111, SLT 0010, SLTU 0011.
- OP (0110011): op1=rs1, op2=rs2. funct3/funct7 select the code. funct7 0100000 is legal only with funct3 000 (SUB) or 101 (SRA). Any other funct7 than 0000000/0100000 → illegal.
- OP-IMM (0010011): op1=rs1, op2=sign-extended I-immediate. SLLI requires imm[11:5]=0. SRLI/SRAI require imm[11:5] of 0000000/0100000. For all shifts op2={27'b0, shamt}. There is no SUBI; funct7 on ADDI is ignored.
- LUI: op1=0, op2={imm[31:12],12'b0}, ADD. AUIPC: op1=pc, same op2, ADD.
- LOAD: op1=rs1, op2=I-imm, ADD, is_load. STORE: op1=rs1, op2=S-imm, ADD, is_store, store_data=rs2.
- BRANCH: op1=rs1, op2=rs2, is_branch. BEQ/BNE → SUB (execute uses zero). BLT/BGE → SLT. BLTU/BGEU → SLTU. funct3 010/011 → illegal.
- JAL/JALR: op1=pc, op2=4, ADD (link value), is_jump. JALR requires funct3=000.
- Any other opcode, or any illegal encoding: out_illegal=1, aluctrl=0000, op1=op2=store_data=0, all other class flags 0. The instruction still issues as a normal beat.
- in_ready = !out_valid || out_ready (full throughput, no bubble).
- Capture on in_valid && in_ready. out_valid next = capture ? 1 : (out_ready ? 0 : out_valid).
- While out_valid && !out_ready, all out_* stay stable.

## Timing
- Latency 1 cycle: beat accepted at edge N is visible on out_* after edge N.
- Back-to-back beats sustain 1 instruction/cycle when out_ready=1.
- Reset (async assert, removal synchronous to clk): out_valid=0, every data/flag output 0, aluctrl=0000. in_ready=1 during and after reset.
- Reset mid-stall drops the held beat. No beat is accepted while rst_n=0.
- Decoding is purely from the captured inputs. There is no dependence on previous beats and no forwarding.

## Configuration
- ALU_ISSUE_FLUSH_EN defined: flush port exists.
  - flush=1 at an edge forces out_valid=0 and blocks capture that cycle.
  - in_ready is forced 0 while flush=1.
  - Flush has priority over out_ready and in_valid.
- ALU_ISSUE_FLUSH_EN undefined: no flush port and no flush logic.

## Test plan
- Reset, then send `sub x3,x1,x2` (0x402081B3) with rs1=10, rs2=3, out_ready=1 → next cycle out_valid=1, aluctrl=1000, op1=10, op2=3.
- `srai x5,x6,4` (0x40435293) with rs1=0xF0000000 → aluctrl=1111, op2=4. Same encoding with imm[11:5]=0x10 → out_illegal=1, aluctrl=0000, operands 0.
- `bltu` (funct3 110) with rs1=1, rs2=2 → is_branch=1, aluctrl=0011, out_funct3=110. `jal` at pc=0x100 → op1=0x100, op2=4, is_jump=1.
- Stream 4 instructions with out_ready low on cycles 2–3 → in_ready low while full. Outputs hold stable, no beat is lost or duplicated, and order is preserved.
- Assert rst_n low while a beat is stalled → out_valid and all outputs 0 immediately, without waiting for a clock edge.
- With ALU_ISSUE_FLUSH_EN: flush coincident with in_valid and a stalled output → out_valid=0 next cycle, in_ready=0 during flush, and the new beat is not captured.
